// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: reset PC, redirect priority,
// fetch-queue entry layout and counter sizing.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Redirect sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_ERET   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_BRANCH = 3'd4
  } redirect_sel_e;

  // Pick the highest-priority asserted redirect source.
  function automatic redirect_sel_e redirect_select(input logic eret_v,
                                                    input logic jump_v,
                                                    input logic jr_v,
                                                    input logic branch_v);
    if (eret_v)   return SEL_ERET;
    if (jump_v)   return SEL_JUMP;
    if (jr_v)     return SEL_JR;
    if (branch_v) return SEL_BRANCH;
    return SEL_NONE;
  endfunction

  // Queue entry layout, MSB to LSB: {pc[width], instr[width], adel}.
  localparam int ENTRY_ADEL_BIT = 0;

  function automatic int entry_width(input int width);
    return 2 * width + 1;
  endfunction

  // Counters must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: synchronous FIFO with flush. Pointers carry one extra MSB so
// full and empty are distinguished without a separate occupancy register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = CW'(wr_ptr_reg - rd_ptr_reg);

  // A push into a full queue is accepted when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  // Pointer update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage; a push that coincides with a flush is dropped.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues pipelined memory requests under
// a credit limit, tracks in-flight responses and buffers results for decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] eret_addr,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             stall,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  input  logic             inst_data_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_add_4,
  output logic             out_adel
);

  localparam int EW = entry_width(WIDTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int SW = CW + 2;

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]    live_reg, live_next;
  logic [CW-1:0]    discard_reg, discard_next;
  logic             halted_reg, halted_next;

  logic             redirect;
  redirect_sel_e    redirect_sel;
  logic [WIDTH-1:0] target;
  logic             aligned;
  logic [SW-1:0]    inflight;
  logic             accept;
  logic             resp_keep;
  logic             resp_drop;
  logic             adel_push;

  logic             q_push;
  logic [EW-1:0]    q_push_data;
  logic             q_pop;
  logic [EW-1:0]    q_head;
  logic             q_full;
  logic             q_empty;
  logic [CW-1:0]    q_count;

  assign redirect     = eret_valid | jump_valid | jr_valid | branch_valid;
  assign redirect_sel = redirect_select(eret_valid, jump_valid, jr_valid, branch_valid);

  // Redirect target mux following the fixed priority order.
  always_comb begin
    target = branch_addr;
    case (redirect_sel)
      SEL_ERET: target = eret_addr;
      SEL_JUMP: target = jump_addr;
      SEL_JR:   target = jr_addr;
      default:  target = branch_addr;
    endcase
  end

  // Every accepted request, pending discard and queued entry holds a credit,
  // so a response always finds room in the queue.
  assign aligned   = (pc_reg[1:0] == 2'b00);
  assign inflight  = SW'(live_reg) + SW'(discard_reg) + SW'(q_count);
  assign inst_req  = !rst && !stall && !redirect && !halted_reg && aligned &&
                     (inflight < SW'(DEPTH));
  assign inst_addr = pc_reg;
  assign accept    = inst_req && inst_addr_ok;

  // Responses to requests issued before a redirect are dropped first.
  assign resp_drop = inst_data_ok && (discard_reg != '0);
  assign resp_keep = inst_data_ok && (discard_reg == '0);

  // A misaligned PC becomes a single address-error entry once earlier
  // fetches have drained, then fetch halts until the next redirect.
  assign adel_push = !redirect && !halted_reg && !aligned && (live_reg == '0) && !q_full;

  assign q_push      = resp_keep || adel_push;
  assign q_push_data = resp_keep ? {resp_pc_reg, inst_rdata, 1'b0}
                                 : {pc_reg, {WIDTH{1'b0}}, 1'b1};

  assign out_valid    = !q_empty && !redirect;
  assign q_pop        = out_valid && out_ready;
  assign out_pc       = q_head[EW-1 -: WIDTH];
  assign out_instr    = q_head[WIDTH:1];
  assign out_adel     = q_head[ENTRY_ADEL_BIT];
  assign out_pc_add_4 = out_pc + WIDTH'(4);

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Next-state for PC, response PC, credit counters and the halt flag.
  always_comb begin
    pc_next      = pc_reg;
    resp_pc_next = resp_pc_reg;
    live_next    = live_reg;
    discard_next = discard_reg;
    halted_next  = halted_reg;
    if (redirect) begin
      pc_next      = target;
      resp_pc_next = target;
      live_next    = '0;
      // Live requests become discards, except one whose data lands now
      // (it is already gone via the flush); a dropped response retires one.
      discard_next = discard_reg + live_reg - CW'(resp_keep) - CW'(resp_drop);
      halted_next  = 1'b0;
    end else begin
      if (accept)    pc_next      = pc_reg + WIDTH'(4);
      if (resp_keep) resp_pc_next = resp_pc_reg + WIDTH'(4);
      live_next = live_reg + CW'(accept) - CW'(resp_keep);
      if (resp_drop) discard_next = discard_reg - CW'(1);
      if (adel_push) halted_next  = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      resp_pc_reg <= RESET_PC;
      live_reg    <= '0;
      discard_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      resp_pc_reg <= resp_pc_next;
      live_reg    <= live_next;
      discard_reg <= discard_next;
      halted_reg  <= halted_next;
    end
  end

endmodule
